// File: rtl/frame_buffer_reader.sv
// Frame buffer reader: fetches one frame from the display buffer in fixed-size
// bursts, stores the returned pixels in a FIFO and hands them to the display
// one per pop. Request issue is credit-limited so that stored plus in-flight
// pixels never exceed the FIFO capacity.
module frame_buffer_reader #(
  parameter int          FB_WIDTH   = 320,
  parameter int          FB_HEIGHT  = 240,
  parameter logic [19:0] FB0_BASE   = 20'h00000,
  parameter logic [19:0] FB1_BASE   = 20'h20000,
  parameter int          BURST      = 16,
  parameter int          FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flip,
  input  logic        frame_start,
  output logic        rd_req_valid,
  input  logic        rd_req_ready,
  output logic [19:0] rd_req_addr,
  output logic [4:0]  rd_req_len,
  input  logic        rd_data_valid,
  input  logic [23:0] rd_data,
  input  logic        pix_req,
  output logic [23:0] pix_data,
  output logic        frame_done,
  output logic        underflow,
  output logic        overrun
);

  localparam int TOTAL = FB_WIDTH * FB_HEIGHT;
  localparam int IDX_W = $clog2(TOTAL + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  // Wide enough for occupancy + outstanding + one burst without overflow.
  localparam int SW    = AW + 3;

  localparam logic [IDX_W-1:0] TOTAL_I = IDX_W'(TOTAL);
  localparam logic [IDX_W-1:0] BURST_I = IDX_W'(BURST);
  localparam logic [IDX_W-1:0] ONE_I   = IDX_W'(1);
  localparam logic [PW-1:0]    BURST_P = PW'(BURST);
  localparam logic [PW-1:0]    ONE_P   = PW'(1);
  localparam logic [PW-1:0]    DEPTH_P = PW'(FIFO_DEPTH);
  localparam logic [SW-1:0]    DEPTH_S = SW'(FIFO_DEPTH);
  localparam logic [SW-1:0]    BURST_S = SW'(BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic [IDX_W-1:0] req_idx_q, req_idx_d;
  logic [IDX_W-1:0] rx_idx_q, rx_idx_d;
  logic [PW-1:0]    outst_q, outst_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [23:0]      pix_q, pix_d;
  logic             done_q, done_d;
  logic             unf_q, unf_d;
  logic             ovr_q, ovr_d;

  logic [23:0]      mem [FIFO_DEPTH];

  logic [PW-1:0]    occ;
  logic             fifo_empty;
  logic             fifo_full;
  logic [SW-1:0]    credit_need;
  logic             req_valid;
  logic             req_fire;
  logic             start_acc;
  logic             resp;
  logic             push;
  logic [19:0]      base;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign occ         = wr_ptr_q - rd_ptr_q;
  assign fifo_empty  = (occ == '0);
  assign fifo_full   = (occ == DEPTH_P);
  assign credit_need = SW'(occ) + SW'(outst_q) + BURST_S;

  // Valid depends only on registered state, so it cannot drop before the
  // handshake: pops only free space and responses move credit from
  // outstanding into occupancy without changing the sum.
  assign req_valid = (state_q == FETCH) && (req_idx_q < TOTAL_I) &&
                     (credit_need <= DEPTH_S);
  assign req_fire  = req_valid && rd_req_ready;
  assign start_acc = (state_q == IDLE) && frame_start;
  // Responses landing while IDLE belong to an aborted frame and are dropped.
  assign resp      = rd_data_valid && (state_q != IDLE);
  assign push      = resp && !fifo_full;

  assign base         = sel_q ? FB1_BASE : FB0_BASE;
  assign rd_req_valid = req_valid;
  assign rd_req_addr  = base + 20'(req_idx_q);
  assign rd_req_len   = 5'(BURST);
  assign pix_data     = pix_q;
  assign frame_done   = done_q;
  assign underflow    = unf_q;
  assign overrun      = ovr_q;

  // Next-state logic for the frame FSM, counters, FIFO pointers and flags.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    req_idx_d = req_idx_q;
    rx_idx_d  = rx_idx_q;
    outst_d   = outst_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pix_d     = pix_q;
    done_d    = 1'b0;
    unf_d     = unf_q;
    ovr_d     = ovr_q;

    // A pop coinciding with an accepted frame start is lost in the flush.
    if (pix_req && !start_acc) begin
      if (!fifo_empty) begin
        pix_d    = mem[rd_ptr_q[AW-1:0]];
        rd_ptr_d = rd_ptr_q + ONE_P;
      end else begin
        pix_d = '0;
        unf_d = 1'b1;
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + ONE_P;
    end
    if (resp && fifo_full) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          sel_d     = ~flip;
          req_idx_d = '0;
          rx_idx_d  = '0;
          outst_d   = '0;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          unf_d     = 1'b0;
          state_d   = FETCH;
        end
      end
      FETCH, DRAIN: begin
        if (frame_start) begin
          ovr_d = 1'b1;
        end
        if (req_fire) begin
          req_idx_d = req_idx_q + BURST_I;
          if (req_idx_q + BURST_I >= TOTAL_I) begin
            state_d = DRAIN;
          end
        end
        outst_d = outst_q + (req_fire ? BURST_P : '0) - (resp ? ONE_P : '0);
        if (resp) begin
          rx_idx_d = rx_idx_q + ONE_I;
          if (rx_idx_q + ONE_I == TOTAL_I) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and flag registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      req_idx_q <= '0;
      rx_idx_q  <= '0;
      outst_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pix_q     <= '0;
      done_q    <= 1'b0;
      unf_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      req_idx_q <= req_idx_d;
      rx_idx_q  <= rx_idx_d;
      outst_q   <= outst_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pix_q     <= pix_d;
      done_q    <= done_d;
      unf_q     <= unf_d;
      ovr_q     <= ovr_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= rd_data;
    end
  end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Scoreboard bench for frame_buffer_reader on a reduced 16x4 frame with
// 4-pixel bursts and a 16-entry FIFO, against a simple in-order memory model.
module tb_frame_buffer_reader;

  localparam int          W   = 16;
  localparam int          H   = 4;
  localparam int          TOT = W * H;
  localparam int          BST = 4;
  localparam int          DEP = 16;
  localparam logic [19:0] B0  = 20'h00000;
  localparam logic [19:0] B1  = 20'h20000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flip = 1'b0;
  logic        frame_start = 1'b0;
  logic        rd_req_valid;
  logic        rd_req_ready = 1'b0;
  logic [19:0] rd_req_addr;
  logic [4:0]  rd_req_len;
  logic        rd_data_valid = 1'b0;
  logic [23:0] rd_data = '0;
  logic        pix_req = 1'b0;
  logic [23:0] pix_data;
  logic        frame_done;
  logic        underflow;
  logic        overrun;

  frame_buffer_reader #(
    .FB_WIDTH  (W),
    .FB_HEIGHT (H),
    .FB0_BASE  (B0),
    .FB1_BASE  (B1),
    .BURST     (BST),
    .FIFO_DEPTH(DEP)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flip         (flip),
    .frame_start  (frame_start),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_req_len   (rd_req_len),
    .rd_data_valid(rd_data_valid),
    .rd_data      (rd_data),
    .pix_req      (pix_req),
    .pix_data     (pix_data),
    .frame_done   (frame_done),
    .underflow    (underflow),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] a;
    int          t;
  } resp_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 2;
  int          n_hs = 0;
  int          fd_count = 0;
  int          h0 = 0;
  logic        pend_pix = 1'b0;
  logic [19:0] exp_addr[$];
  logic [23:0] exp_pix[$];
  resp_t       mem_q[$];

  function automatic logic [23:0] pix(input logic [19:0] a);
    return {4'h5, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and memory model, evaluated mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (pend_pix) begin
      pend_pix = 1'b0;
      if (exp_pix.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pix_scoreboard: pop with no expected value, pix_data %0h", pix_data);
      end else begin
        check("pix_data", 32'(pix_data), 32'(exp_pix.pop_front()));
      end
    end
    if (pix_req && resetn) pend_pix = 1'b1;

    if (rd_req_valid && rd_req_ready && resetn) begin
      n_hs++;
      check("rd_req_len", 32'(rd_req_len), BST);
      if (exp_addr.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_request: addr %0h, none expected", rd_req_addr);
      end else begin
        check("rd_req_addr", 32'(rd_req_addr), 32'(exp_addr.pop_front()));
      end
      for (int i = 0; i < BST; i++) begin
        mem_q.push_back('{a: rd_req_addr + 20'(i), t: cyc + lat});
      end
    end

    if (mem_q.size() > 0 && mem_q[0].t <= cyc) begin
      rd_data_valid = 1'b1;
      rd_data       = pix(mem_q[0].a);
      void'(mem_q.pop_front());
    end else begin
      rd_data_valid = 1'b0;
    end

    if (frame_done) fd_count++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame(input logic f, input logic [19:0] base);
    flip = f;
    for (int k = 0; k < TOT / BST; k++) exp_addr.push_back(base + 20'(k * BST));
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  task automatic pop_one(input logic [23:0] e);
    pix_req = 1'b1;
    exp_pix.push_back(e);
    step(1);
    pix_req = 1'b0;
  endtask

  task automatic pop_frame(input logic [19:0] base, input int from);
    for (int i = from; i < TOT; i++) begin
      pop_one(pix(base + 20'(i)));
      step(3);
    end
  endtask

  task automatic wait_fd(input int target);
    int k;
    k = 0;
    while (fd_count < target && k < 500) begin
      step(1);
      k++;
    end
    step(2);
    check("frame_done_count", fd_count, target);
  endtask

  task automatic frame_end_checks(input string tag);
    check({tag, "_requests"}, n_hs - h0, TOT / BST);
    check({tag, "_addr_left"}, exp_addr.size(), 0);
    check({tag, "_pix_left"}, exp_pix.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    step(3);
    check("rst_rd_req_valid", rd_req_valid, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_underflow", underflow, 0);
    check("rst_overrun", overrun, 0);
    resetn = 1'b1;
    step(2);

    // flip=0 reads buffer 1; credit limit with no pops, then full frame
    rd_req_ready = 1'b1;
    h0 = n_hs;
    start_frame(1'b0, B1);
    step(30);
    check("credit_hs", n_hs - h0, DEP / BST);
    check("credit_valid_low", rd_req_valid, 0);
    for (int i = 0; i < BST; i++) pop_one(pix(B1 + 20'(i)));
    step(3);
    check("credit_hs_after_pops", n_hs - h0, DEP / BST + 1);
    pop_frame(B1, BST);
    wait_fd(1);
    frame_end_checks("f1");
    check("f1_overrun", overrun, 0);
    check("f1_underflow", underflow, 0);

    // flip=1 reads buffer 0; flip toggled mid-frame must not move addresses
    h0 = n_hs;
    start_frame(1'b1, B0);
    step(3);
    flip = 1'b0;
    step(27);
    pop_frame(B0, 0);
    wait_fd(2);
    frame_end_checks("f2");

    // Pop on empty FIFO right after frame start
    h0 = n_hs;
    start_frame(1'b0, B1);
    pop_one(24'h000000);
    step(1);
    check("underflow_set", underflow, 1);
    step(30);
    pop_frame(B1, 0);
    wait_fd(3);
    frame_end_checks("f3");
    check("underflow_sticky", underflow, 1);

    // Next frame_start clears underflow; frame_start mid-FETCH sets overrun only
    h0 = n_hs;
    start_frame(1'b1, B0);
    step(1);
    check("underflow_cleared", underflow, 0);
    step(3);
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    step(1);
    check("overrun_set", overrun, 1);
    step(25);
    pop_frame(B0, 0);
    wait_fd(4);
    frame_end_checks("f4");
    check("overrun_sticky", overrun, 1);

    // Reset mid-FETCH with 8 pixels outstanding; late responses discarded
    lat = 20;
    rd_req_ready = 1'b0;
    h0 = n_hs;
    start_frame(1'b0, B1);
    step(2);
    rd_req_ready = 1'b1;
    step(2);
    rd_req_ready = 1'b0;
    check("hs_before_reset", n_hs - h0, 2);
    step(1);
    resetn = 1'b0;
    #1;
    check("arst_rd_req_valid", rd_req_valid, 0);
    check("arst_pix_data", pix_data, 0);
    check("arst_frame_done", frame_done, 0);
    check("arst_underflow", underflow, 0);
    check("arst_overrun", overrun, 0);
    exp_addr.delete();
    step(3);
    resetn = 1'b1;
    step(40);
    pop_one(24'h000000);
    step(1);
    check("late_resp_underflow", underflow, 1);

    // Fresh frame after reset starts at the buffer base
    lat = 2;
    rd_req_ready = 1'b1;
    h0 = n_hs;
    start_frame(1'b0, B1);
    step(1);
    check("f5_underflow_cleared", underflow, 0);
    check("f5_overrun", overrun, 0);
    step(28);
    pop_frame(B1, 0);
    wait_fd(5);
    frame_end_checks("f5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
